// File: rtl/sam_burst_cmd_gen.sv
// Burst descriptor -> sam command word stream (STORE/LOAD), cmd_last on the final word.
// Optional descriptor bounds check enabled by SAM_CMD_GEN_BOUNDS_EN.
module sam_burst_cmd_gen #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 16384
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic              desc_op,
    input  logic [ADDR_W-1:0] desc_addr,
    input  logic [ADDR_W-1:0] desc_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [31:0]       cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_last,
    output logic              busy,
    output logic              err
);

    if (2 + ADDR_W + DATA_W != 32 || MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_W)) begin : g_bad_params
        $error("sam_burst_cmd_gen: inconsistent ADDR_W/DATA_W/MEM_DEPTH");
    end

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t            state;
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic              slot_free;
    logic              gen;
    logic              desc_oob;
    logic [31:0]       next_word;

    // Slot is free when nothing is pending or the pending word leaves this cycle.
    assign slot_free   = !cmd_valid || cmd_ready;
    assign desc_ready  = rstn && (state == IDLE);
    assign wdata_ready = rstn && (state == ISSUE) && !op && slot_free;
    assign gen         = (state == ISSUE) && slot_free && (op || wdata_valid);
    assign next_word   = op ? {2'b01, addr, {DATA_W{1'b0}}} : {2'b00, addr, wdata};
    assign busy        = (state != IDLE) || cmd_valid;

`ifdef SAM_CMD_GEN_BOUNDS_EN
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_DEPTH);
    assign desc_oob = ({1'b0, desc_addr} + {1'b0, desc_len}) >= MEM_LIM;
`else
    assign desc_oob = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            op        <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            cmd_last  <= 1'b0;
`ifdef SAM_CMD_GEN_BOUNDS_EN
            err       <= 1'b0;
`endif
        end else begin
`ifdef SAM_CMD_GEN_BOUNDS_EN
            err <= 1'b0;
`endif
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                cmd_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (desc_valid && !desc_oob) begin
                        op        <= desc_op;
                        addr      <= desc_addr;
                        remaining <= desc_len;
                        state     <= ISSUE;
                    end
`ifdef SAM_CMD_GEN_BOUNDS_EN
                    if (desc_valid && desc_oob) err <= 1'b1;
`endif
                end
                ISSUE: begin
                    // A new word overrides the handshake clear above.
                    if (gen) begin
                        cmd_valid <= 1'b1;
                        cmd_data  <= next_word;
                        cmd_last  <= (remaining == '0);
                        addr      <= addr + 1'b1;
                        if (remaining == '0) state <= IDLE;
                        else                 remaining <= remaining - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sam_burst_cmd_gen.sv
// Table-driven bench for sam_burst_cmd_gen with a scoreboard of expected command words.
module tb_sam_burst_cmd_gen;
    localparam int AW = 14;
    localparam int DW = 16;
`ifdef SAM_CMD_GEN_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic          desc_op = 1'b0;
    logic [AW-1:0] desc_addr = '0;
    logic [AW-1:0] desc_len = '0;
    logic [DW-1:0] wdata = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [31:0]   cmd_data;
    logic          cmd_valid;
    logic          cmd_ready = 1'b1;
    logic          cmd_last;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    sam_burst_cmd_gen dut (
        .clk(clk), .rstn(rstn),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_op(desc_op),
        .desc_addr(desc_addr), .desc_len(desc_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_last(cmd_last), .busy(busy), .err(err)
    );

    typedef struct {
        logic              op;
        logic [AW-1:0]     addr;
        logic [AW-1:0]     len;
        logic [3:0][DW-1:0] wd;
        bit                toggle;
        int                gap_at;
        int                gap_len;
        logic [31:0]       exp_first;
        int                exp_n;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] wq[$];
    vec_t          vecs[7];
    vec_t          vpost;

    int tests = 0, fails = 0, cyc = 0;
    bit tog = 0;
    int gap = 0, gap_idle = 0, st_cnt = 0, gap_at = -1, gap_len = 0;
    bit ex_active = 0, ex_op = 0;
    logic [AW-1:0] ex_addr = '0, ex_rem = '0;
    bit stall_prev = 0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    bit err_exp = 0;
    int words = 0, desc_cyc = 0, first_cyc = 0, last_cyc = 0;
    logic [31:0] first_word = '0;
    bit desc_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit oob(input logic [AW-1:0] a, input logic [AW-1:0] l);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, l};
        return BOUNDS_EN && (s >= 15'd16384);
    endfunction

    // One clock: sample at negedge, update model/scoreboard, drive after posedge.
    task automatic step();
        bit   wd_hs, ds_hs;
        exp_t e;
        @(negedge clk);
        check("err", 32'(err), 32'(err_exp));
        err_exp = 0;
        if (stall_prev) begin
            check("hold_valid", 32'(cmd_valid), 32'd1);
            check("hold_data", cmd_data, prev_data);
            check("hold_last", 32'(cmd_last), 32'(prev_last));
        end
        stall_prev = cmd_valid && !cmd_ready;
        prev_data  = cmd_data;
        prev_last  = cmd_last;
        gap_idle = (!wdata_valid && wq.size() > 0) ? gap_idle + 1 : 0;
        if (gap_idle >= 2) check("starved_valid", 32'(cmd_valid), 32'd0);
        if (cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                check("extra_word", cmd_data, 32'hxxxxxxxx);
            end else begin
                e = sb.pop_front();
                check("cmd_data", cmd_data, e.data);
                check("cmd_last", 32'(cmd_last), 32'(e.last));
            end
            if (words == 0) begin
                first_cyc  = cyc;
                first_word = cmd_data;
            end
            last_cyc = cyc;
            words++;
        end
        wd_hs = wdata_valid && wdata_ready;
        if (wd_hs) begin
            if (!(ex_active && !ex_op)) begin
                check("stray_wdata_ready", 32'(wdata_ready), 32'd0);
            end else begin
                e.data = {2'b00, ex_addr, wdata};
                e.last = (ex_rem == '0);
                sb.push_back(e);
                ex_addr = ex_addr + 1'b1;
                if (ex_rem == '0) ex_active = 0;
                else              ex_rem = ex_rem - 1'b1;
            end
            st_cnt++;
        end
        ds_hs = desc_valid && desc_ready;
        if (ds_hs) begin
            desc_done = 1;
            desc_cyc  = cyc;
            if (oob(desc_addr, desc_len)) begin
                err_exp = 1;
            end else if (desc_op) begin
                ex_addr = desc_addr;
                for (int i = 0; i <= int'(desc_len); i++) begin
                    e.data = {2'b01, ex_addr, 16'h0000};
                    e.last = (i == int'(desc_len));
                    sb.push_back(e);
                    ex_addr = ex_addr + 1'b1;
                end
                ex_active = 0;
            end else begin
                ex_active = 1;
                ex_op     = 0;
                ex_addr   = desc_addr;
                ex_rem    = desc_len;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ds_hs) desc_valid = 1'b0;
        if (wd_hs) begin
            wq.delete(0);
            if (st_cnt == gap_at) gap = gap_len;
        end else if (gap > 0) begin
            gap--;
        end
        wdata_valid = (wq.size() > 0) && (gap == 0);
        wdata       = (wq.size() > 0) ? wq[0] : '0;
        cmd_ready   = tog ? !cmd_ready : 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        bit done;
        tog = v.toggle; gap_at = v.gap_at; gap_len = v.gap_len;
        st_cnt = 0; words = 0; desc_done = 0; gap = 0;
        desc_op = v.op; desc_addr = v.addr; desc_len = v.len; desc_valid = 1'b1;
        if (!v.op && !oob(v.addr, v.len)) begin
            for (int i = 0; i <= int'(v.len); i++)
                wq.push_back(i < 4 ? v.wd[i] : v.wd[i % 4] ^ DW'(i));
            wdata_valid = 1'b1;
            wdata       = wq[0];
        end
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            done = desc_done && sb.size() == 0 && wq.size() == 0 && !busy && !err_exp;
        end
        check("burst_done", 32'(done), 32'd1);
        check("n_words", 32'(words), 32'(v.exp_n));
        if (v.exp_n > 0) check("first_word", first_word, v.exp_first);
        if (!v.toggle && v.gap_len == 0 && words > 0)
            check("throughput", 32'(last_cyc - first_cyc), 32'(words - 1));
        if (v.op && !v.toggle && words > 0)
            check("load_latency", 32'(first_cyc - desc_cyc), 32'd2);
        tog = 0;
    endtask

    initial begin
        //            op    addr      len  wd                                        tog gap_at gap_len first          n
        vecs[0] = '{1'b1, 14'd5,     14'd0, {16'h0, 16'h0, 16'h0, 16'h0},          0, -1, 0, 32'h40050000, 1};
        vecs[1] = '{1'b0, 14'd20,    14'd2, {16'h0, 16'h1234, 16'hBEEF, 16'hFACE}, 0, -1, 0, 32'h0014FACE, 3};
        vecs[2] = '{1'b1, 14'd0,     14'd3, {16'h0, 16'h0, 16'h0, 16'h0},          1, -1, 0, 32'h40000000, 4};
        vecs[3] = '{1'b0, 14'd100,   14'd1, {16'h0, 16'h0, 16'h5A5A, 16'hA5A5},    0,  1, 5, 32'h0064A5A5, 2};
        vecs[4] = '{1'b1, 14'd16383, 14'd1, {16'h0, 16'h0, 16'h0, 16'h0},          0, -1, 0, 32'h7FFF0000, 2};
        vecs[5] = '{1'b0, 14'd16383, 14'd1, {16'h0, 16'h0, 16'h0002, 16'h0001},    1, -1, 0, 32'h3FFF0001, 2};
        vecs[6] = '{1'b1, 14'd1000,  14'd7, {16'h0, 16'h0, 16'h0, 16'h0},          1, -1, 0, 32'h43E80000, 8};
        if (BOUNDS_EN) begin
            vecs[4].exp_n = 0;
            vecs[5].exp_n = 0;
        end
        vpost = '{1'b1, 14'd7, 14'd1, {16'h0, 16'h0, 16'h0, 16'h0}, 0, -1, 0, 32'h40070000, 2};

        #2;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_data", cmd_data, 32'd0);
        check("rst_cmd_last", 32'(cmd_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_desc_ready", 32'(desc_ready), 32'd0);
        check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        // wdata offered while idle must not be consumed
        wdata_valid = 1'b1;
        wdata       = 16'h1111;
        @(negedge clk);
        check("idle_wdata_ready", 32'(wdata_ready), 32'd0);
        check("idle_desc_ready", 32'(desc_ready), 32'd1);
        @(posedge clk);
        #1;
        wdata_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a long LOAD burst
        tog = 0; words = 0; desc_done = 0;
        desc_op = 1'b1; desc_addr = 14'd50; desc_len = 14'd9; desc_valid = 1'b1;
        for (int c = 0; c < 100 && words < 3; c++) step();
        check("pre_reset_words", 32'(words), 32'd3);
        rstn = 1'b0;
        #1;
        check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_cmd_data", cmd_data, 32'd0);
        check("mid_rst_cmd_last", 32'(cmd_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_desc_ready", 32'(desc_ready), 32'd0);
        sb.delete();
        stall_prev = 0;
        ex_active  = 0;
        desc_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_desc_ready", 32'(desc_ready), 32'd1);
        @(posedge clk);
        #1;
        run_vec(vpost);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
